// File: rtl/hub_ctrl_pkg.sv
// Shared types and elaboration helpers for the folded linear-layer controller.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
// Contents: state enum, partition-index width, frame length, window counter width.
package hub_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // A single-partition build still needs a 1-bit part port.
  function automatic int part_width(input int fold);
    return (fold > 1) ? $clog2(fold) : 1;
  endfunction

  // LOAD + FOLD*(RUN window + drain) + DONE.
  function automatic int frame_cyc(input int fold, input int rwid, input int pipe);
    return 2 + fold * ((1 << rwid) + pipe);
  endfunction

  // The shared window counter must hold both LEN (RWID+1 bits) and PIPE.
  function automatic int cnt_width(input int rwid, input int pipe);
    int len_w;
    int pipe_w;
    len_w  = rwid + 1;
    pipe_w = $clog2(pipe + 1);
    return (len_w > pipe_w) ? len_w : pipe_w;
  endfunction

  localparam int FRAME_CYC = frame_cyc(2, 10, 1);

endpackage

// File: rtl/hub_win_counter.sv
// Loadable down-counter timing one RUN or DRAIN window; tc flags the window's last cycle.
// Latency: load takes effect at the next edge; tc is a decode of the registered count.
// Backpressure: none; counts only while en is high, clr and ld take priority.
// Ports: clk, rst_n, clr (sync zero), ld/ld_val (window length), en (count), tc (count==1).
module hub_win_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with N, the count reads N..1 over the window, so 1 marks the last cycle.
  assign tc = (cnt_q == W'(1));

endmodule

// File: rtl/hub_linear_fold_ctrl.sv
// Sequencer for a folded SC linear layer: load strobe, partition stepping, window/drain timing.
// Latency: start sampled in IDLE -> load next cycle; frame is 2+FOLD*(2**RWID+PIPE) cycles.
// Backpressure: none; start while busy is dropped, abort returns to IDLE next cycle.
// Ports: clk, rst_n, start, abort in; busy, done, load, clear, sel, part, frame_cnt out (all registered).
module hub_linear_fold_ctrl
  import hub_ctrl_pkg::*;
#(
  parameter int FOLD = 2,
  parameter int RWID = 10,
  parameter int PIPE = 1,
  parameter int PWID = part_width(FOLD)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            load,
  output logic            clear,
  output logic            sel,
  output logic [PWID-1:0] part,
  output logic [15:0]     frame_cnt
);

  localparam int              CW        = cnt_width(RWID, PIPE);
  localparam logic [CW-1:0]   LEN_LD    = CW'(64'd1 << RWID);
  localparam logic [CW-1:0]   PIPE_LD   = CW'(PIPE);
  localparam logic [PWID-1:0] PART_LAST = PWID'(FOLD - 1);

  state_e          state_q, state_d;
  logic [PWID-1:0] part_q, part_d;
  logic            sel_q, sel_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load_q, load_d;
  logic            clear_q, clear_d;

  logic            next_part;
  logic            win_clr;
  logic            win_ld;
  logic [CW-1:0]   win_ld_val;
  logic            win_en;
  logic            win_tc;

  hub_win_counter #(
    .W(CW)
  ) u_win (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (win_clr),
    .ld     (win_ld),
    .ld_val (win_ld_val),
    .en     (win_en),
    .tc     (win_tc)
  );

  always_comb begin
    state_d     = state_q;
    part_d      = part_q;
    sel_d       = sel_q;
    frame_cnt_d = frame_cnt_q;
    clear_d     = 1'b0;
    next_part   = 1'b0;
    win_clr     = 1'b0;
    win_ld      = 1'b0;
    win_ld_val  = '0;
    win_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        part_d = '0;
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d    = ST_RUN;
        part_d     = '0;
        clear_d    = 1'b1;
        win_ld     = 1'b1;
        win_ld_val = LEN_LD;
      end
      ST_RUN: begin
        win_en = 1'b1;
        if (win_tc) begin
          if (PIPE > 0) begin
            state_d    = ST_DRAIN;
            win_ld     = 1'b1;
            win_ld_val = PIPE_LD;
          end else begin
            next_part = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // part is held so in-flight adder-tree sums land in the partition just run.
        win_en = 1'b1;
        if (win_tc) begin
          next_part = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        part_d  = '0;
      end
    endcase

    // End of a partition's window (+drain): either step to the next one or close the frame.
    if (next_part) begin
      if (part_q != PART_LAST) begin
        state_d    = ST_RUN;
        part_d     = part_q + PWID'(1);
        clear_d    = 1'b1;
        win_ld     = 1'b1;
        win_ld_val = LEN_LD;
      end else begin
        state_d     = ST_DONE;
        part_d      = '0;
        sel_d       = ~sel_q;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end

    // Abort overrides everything decided above; sel and frame_cnt keep their values.
    if (abort) begin
      state_d     = ST_IDLE;
      part_d      = '0;
      sel_d       = sel_q;
      frame_cnt_d = frame_cnt_q;
      clear_d     = 1'b0;
      win_clr     = 1'b1;
      win_ld      = 1'b0;
      win_en      = 1'b0;
    end

    // Outputs describe the state being entered, so they line up with state_q next cycle.
    busy_d = (state_d != ST_IDLE);
    load_d = (state_d == ST_LOAD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      part_q      <= '0;
      sel_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_q      <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      part_q      <= part_d;
      sel_q       <= sel_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_q      <= load_d;
      clear_q     <= clear_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign load      = load_q;
  assign clear     = clear_q;
  assign sel       = sel_q;
  assign part      = part_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hub_linear_fold_ctrl.sv
// Bench for hub_linear_fold_ctrl: two instances (FOLD=2/RWID=2/PIPE=1 and FOLD=1/RWID=3/PIPE=0)
// checked every cycle against a frame-position model: k counts cycles since start was taken,
// and every output is a plain arithmetic function of k, LEN, PIPE and FOLD.
module tb_hub_linear_fold_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_a = 1'b0, abort_a = 1'b0;
  logic        start_b = 1'b0, abort_b = 1'b0;

  logic        busy_a, done_a, load_a, clear_a, sel_a;
  logic [0:0]  part_a;
  logic [15:0] frame_cnt_a;
  logic        busy_b, done_b, load_b, clear_b, sel_b;
  logic [0:0]  part_b;
  logic [15:0] frame_cnt_b;

  hub_linear_fold_ctrl #(.FOLD(2), .RWID(2), .PIPE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .load(load_a), .clear(clear_a),
    .sel(sel_a), .part(part_a), .frame_cnt(frame_cnt_a)
  );

  hub_linear_fold_ctrl #(.FOLD(1), .RWID(3), .PIPE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .load(load_b), .clear(clear_b),
    .sel(sel_b), .part(part_b), .frame_cnt(frame_cnt_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  int          p_fold[2] = '{2, 1};
  int          p_len[2]  = '{4, 8};
  int          p_pipe[2] = '{1, 0};
  int          m_k[2];
  logic        m_sel[2];
  logic [15:0] m_cnt[2];

  function automatic int last_k(input int d);
    return 2 + p_fold[d] * (p_len[d] + p_pipe[d]);
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_k[d]   = 0;
      m_sel[d] = 1'b0;
      m_cnt[d] = 16'd0;
    end
  endfunction

  function automatic void model_edge(input int d, input logic st, input logic ab);
    if (ab) begin
      m_k[d] = 0;
    end else if (m_k[d] == 0) begin
      m_k[d] = st ? 1 : 0;
    end else if (m_k[d] == last_k(d)) begin
      m_k[d] = 0;
    end else begin
      m_k[d] = m_k[d] + 1;
      if (m_k[d] == last_k(d)) begin
        m_sel[d] = ~m_sel[d];
        m_cnt[d] = m_cnt[d] + 16'd1;
      end
    end
  endfunction

  // {busy, done, load, clear, sel, part, frame_cnt}
  function automatic logic [21:0] exp_vec(input int d);
    int   k, j, w;
    logic b, dn, ld, cl, pt;
    k = m_k[d];
    w = p_len[d] + p_pipe[d];
    b = 1'b0; dn = 1'b0; ld = 1'b0; cl = 1'b0; pt = 1'b0;
    if (k == 1) begin
      b = 1'b1; ld = 1'b1;
    end else if (k == last_k(d)) begin
      b = 1'b1; dn = 1'b1;
    end else if (k >= 2) begin
      j  = k - 2;
      b  = 1'b1;
      cl = ((j % w) == 0);
      pt = 1'(j / w);
    end
    return {b, dn, ld, cl, m_sel[d], pt, m_cnt[d]};
  endfunction

  function automatic logic [21:0] obs_vec(input int d);
    if (d == 0) return {busy_a, done_a, load_a, clear_a, sel_a, part_a, frame_cnt_a};
    return {busy_b, done_b, load_b, clear_b, sel_b, part_b, frame_cnt_b};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0, start_a, abort_a);
      model_edge(1, start_b, abort_b);
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (obs_vec(d) !== exp_vec(d)) begin
        n_miss++;
        $display("FAIL reset_state dut=%0d got=%h exp=%h", d, obs_vec(d), exp_vec(d));
      end
    end
    #9 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_miss++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_basic_frame();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) step();
      n_vec++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_miss++;
        $display("FAIL basic_frame c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] base;
    base = frame_cnt_a;
    start_a = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      step();
      n_vec++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_miss++;
        $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
      end
      if (c == 25) start_a = 1'b0;
    end
    n_vec++;
    if (frame_cnt_a !== base + 16'd2) begin
      n_miss++;
      $display("FAIL b2b_frame_cnt got=%0d exp=%0d", frame_cnt_a, base + 16'd2);
    end
    for (int c = 0; c < 14; c++) step();
  endtask

  task automatic test_abort();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) step();
      if (c == 8) abort_a = 1'b1;
      else abort_a = 1'b0;
      n_vec++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_miss++;
        $display("FAIL abort c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
      end
    end
    abort_a = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) step();
      n_vec++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_miss++;
        $display("FAIL abort_refill c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_single_fold();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) step();
      n_vec++;
      if (obs_vec(1) !== exp_vec(1)) begin
        n_miss++;
        $display("FAIL single_fold c=%0d got=%h exp=%h", c, obs_vec(1), exp_vec(1));
      end
    end
  endtask

  task automatic test_async_reset();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 2; c <= 6; c++) step();
    n_vec++;
    if (obs_vec(0) !== exp_vec(0)) begin
      n_miss++;
      $display("FAIL pre_reset_drain got=%h exp=%h", obs_vec(0), exp_vec(0));
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (obs_vec(d) !== exp_vec(d)) begin
        n_miss++;
        $display("FAIL async_reset dut=%0d got=%h exp=%h", d, obs_vec(d), exp_vec(d));
      end
    end
    #4 rst_n = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) step();
      n_vec++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_miss++;
        $display("FAIL post_reset_frame c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_wrap();
    int dones;
    force dut_a.frame_cnt_q = 16'hFFFF;
    m_cnt[0] = 16'hFFFF;
    #1;
    release dut_a.frame_cnt_q;
    step();
    n_vec++;
    if (obs_vec(0) !== exp_vec(0)) begin
      n_miss++;
      $display("FAIL wrap_preload got=%h exp=%h", obs_vec(0), exp_vec(0));
    end
    dones = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) step();
      if (done_a === 1'b1) dones++;
      n_vec++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_miss++;
        $display("FAIL wrap_frame c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
      end
    end
    n_vec++;
    if (frame_cnt_a !== 16'h0000 || dones != 1) begin
      n_miss++;
      $display("FAIL wrap_result frame_cnt=%h dones=%0d exp frame_cnt=0000 dones=1", frame_cnt_a, dones);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      start_a = ($urandom_range(0, 3) == 0);
      abort_a = ($urandom_range(0, 30) == 0);
      start_b = ($urandom_range(0, 2) == 0);
      abort_b = ($urandom_range(0, 25) == 0);
      step();
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_miss++;
          $display("FAIL random cyc=%0d dut=%0d got=%h exp=%h", cyc, d, obs_vec(d), exp_vec(d));
        end
      end
    end
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_abort();
    test_single_fold();
    test_async_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
